// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two packed request lanes plus one shared response.
// The master modport is the requester side; the slave modport is the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [7:0]          req_byte_en;
    logic [63:0]         req_wdata;
    logic                rsp_valid;
    logic                rsp_id;
    logic [31:0]         rsp_data;
    logic                rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_byte_en, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_byte_en, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_error
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (0) and the loader/debug port (1).
// Sub-word stores take a read cycle (merge) followed by a write cycle in RMW_WR.
//
// state  | meaning
// IDLE   | arbitrate; loads, full/empty stores and errors complete here
// RMW_WR | write the merged word of a partial store; no new grants
module dmem_arbiter #(
    parameter int MEM_WORDS = 7920,
    parameter int ADDR_W    = 16
) (
    input  logic         clock,
    input  logic         reset,
    dmem_arbiter_if.slave bus,
    output logic [13:0]  mem_address,
    output logic         mem_write_enable,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data
);
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state_q, state_d;
    logic        rr_next_q, rr_next_d;
    logic [13:0] rmw_addr_q, rmw_addr_d;
    logic        rmw_id_q, rmw_id_d;
    logic [31:0] merged_q, merged_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_error_q, rsp_error_d;

    logic              gnt;
    logic              gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wdata;
    logic              sel_write;
    logic [13:0]       word_addr;
    logic              req_err;

    always_comb begin
        gnt_id    = (&bus.req_valid) ? rr_next_q : bus.req_valid[1];
        gnt       = (state_q == IDLE) && !reset && (|bus.req_valid);
        sel_addr  = gnt_id ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        sel_be    = gnt_id ? bus.req_byte_en[7:4] : bus.req_byte_en[3:0];
        sel_wdata = gnt_id ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
        sel_write = gnt_id ? bus.req_write[1] : bus.req_write[0];
        word_addr = sel_addr[15:2];
        req_err   = (sel_addr[1:0] != 2'b00) || ({18'd0, word_addr} >= MEM_WORDS[31:0]);
    end

    always_comb begin
        state_d          = state_q;
        rr_next_d        = rr_next_q;
        rmw_addr_d       = rmw_addr_q;
        rmw_id_d         = rmw_id_q;
        merged_d         = merged_q;
        rsp_valid_d      = 1'b0;
        rsp_id_d         = rsp_id_q;
        rsp_data_d       = 32'd0;
        rsp_error_d      = 1'b0;
        bus.req_ready    = 2'b00;
        mem_address      = 14'd0;
        mem_write_enable = 1'b0;
        mem_write_data   = 32'd0;
        case (state_q)
            IDLE: begin
                if (gnt) begin
                    bus.req_ready = gnt_id ? 2'b10 : 2'b01;
                    mem_address   = word_addr;
                    rr_next_d     = ~gnt_id;
                    if (sel_write && !req_err && (sel_be != 4'b1111) && (sel_be != 4'b0000)) begin
                        for (int b = 0; b < 4; b++) begin
                            merged_d[8*b +: 8] = sel_be[b] ? sel_wdata[8*b +: 8]
                                                           : mem_read_data[8*b +: 8];
                        end
                        rmw_addr_d = word_addr;
                        rmw_id_d   = gnt_id;
                        state_d    = RMW_WR;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = gnt_id;
                        rsp_error_d = req_err;
                        rsp_data_d  = (!sel_write && !req_err) ? mem_read_data : 32'd0;
                        if (sel_write && !req_err && (sel_be == 4'b1111)) begin
                            mem_write_enable = 1'b1;
                            mem_write_data   = sel_wdata;
                        end
                    end
                end
            end
            RMW_WR: begin
                // reset in this cycle must leave memory untouched
                if (!reset) begin
                    mem_address      = rmw_addr_q;
                    mem_write_enable = 1'b1;
                    mem_write_data   = merged_q;
                end
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_id_d    = rmw_id_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_next_q   <= 1'b0;
            rmw_addr_q  <= 14'd0;
            rmw_id_q    <= 1'b0;
            merged_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_next_q   <= rr_next_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_id_q    <= rmw_id_d;
            merged_q    <= merged_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = rsp_error_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
// Inputs change 1 time unit after the rising edge; combinational outputs are checked 1 unit later.
module tb_dmem_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [31:0] mem [0:16383];
    int          n_checks = 0;
    int          n_errors = 0;

    dmem_arbiter_if #(.ADDR_W(16)) bus ();

    dmem_arbiter #(.MEM_WORDS(7920), .ADDR_W(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (mem_write_enable) mem[mem_address] <= mem_write_data;
    assign mem_read_data = mem[mem_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear();
        bus.req_valid   = 2'b00;
        bus.req_write   = 2'b00;
        bus.req_addr    = 32'd0;
        bus.req_byte_en = 8'd0;
        bus.req_wdata   = 64'd0;
    endtask

    task automatic drive(input int id, input logic wr, input logic [15:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        bus.req_valid[id]          = 1'b1;
        bus.req_write[id]          = wr;
        bus.req_addr[16*id +: 16]  = addr;
        bus.req_byte_en[4*id +: 4] = be;
        bus.req_wdata[32*id +: 32] = wd;
    endtask

    // one-cycle transaction: check the grant, then the registered response
    task automatic xact(input string tag, input int id, input logic wr, input logic [15:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic exp_we, input logic [31:0] exp_data, input logic exp_err);
        clear();
        drive(id, wr, addr, be, wd);
        #1;
        check({tag, "_ready"}, 32'(bus.req_ready), (id == 1) ? 32'd2 : 32'd1);
        check({tag, "_we"}, 32'(mem_write_enable), 32'(exp_we));
        tick();
        clear();
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(id));
        check({tag, "_rsp_data"}, bus.rsp_data, exp_data);
        check({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'(exp_err));
    endtask

    initial begin
        clear();
        tick();
        bus.req_valid = 2'b11;
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        tick();
        reset = 1'b0;
        clear();

        // full store then load-back
        drive(0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
        #1;
        check("st_full_addr", 32'(mem_address), 32'd4);
        check("st_full_wdata", mem_write_data, 32'hDEADBEEF);
        clear();
        xact("st_full", 0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
        xact("ld_full", 0, 1'b0, 16'h0010, 4'h0, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0);
        tick();
        check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);

        // partial store on requester 1
        xact("st_w4", 0, 1'b1, 16'h0010, 4'hF, 32'h11223344, 1'b1, 32'd0, 1'b0);
        drive(1, 1'b1, 16'h0010, 4'b0010, 32'h0000AB00);
        #1;
        check("rmw_ready_acc", 32'(bus.req_ready), 32'd2);
        check("rmw_we_acc", 32'(mem_write_enable), 32'd0);
        tick();
        clear();
        #1;
        check("rmw_ready_wr", 32'(bus.req_ready), 32'd0);
        check("rmw_we_wr", 32'(mem_write_enable), 32'd1);
        check("rmw_addr_wr", 32'(mem_address), 32'd4);
        check("rmw_wdata", mem_write_data, 32'h1122AB44);
        check("rmw_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("rmw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rmw_rsp_id", 32'(bus.rsp_id), 32'd1);
        check("rmw_rsp_data", bus.rsp_data, 32'd0);
        xact("rmw_readback", 0, 1'b0, 16'h0010, 4'h0, 32'd0, 1'b0, 32'h1122AB44, 1'b0);

        // empty store, error cases and the last valid word
        xact("st_be0", 1, 1'b1, 16'h0010, 4'h0, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0);
        xact("be0_readback", 0, 1'b0, 16'h0010, 4'h0, 32'd0, 1'b0, 32'h1122AB44, 1'b0);
        xact("err_range", 0, 1'b1, 16'h7BC0, 4'hF, 32'h55555555, 1'b0, 32'd0, 1'b1);
        xact("err_align", 0, 1'b1, 16'h0002, 4'hF, 32'h66666666, 1'b0, 32'd0, 1'b1);
        xact("err_ld_align", 0, 1'b0, 16'h0011, 4'h0, 32'd0, 1'b0, 32'd0, 1'b1);
        xact("err_part", 0, 1'b1, 16'h0012, 4'b0001, 32'h000000AA, 1'b0, 32'd0, 1'b1);
        xact("st_last", 0, 1'b1, 16'h7BBC, 4'hF, 32'hCAFEF00D, 1'b1, 32'd0, 1'b0);
        xact("ld_last", 0, 1'b0, 16'h7BBC, 4'h0, 32'd0, 1'b0, 32'hCAFEF00D, 1'b0);

        // round robin after a fresh reset
        xact("st_w1", 0, 1'b1, 16'h0004, 4'hF, 32'hA1A1A1A1, 1'b1, 32'd0, 1'b0);
        xact("st_w2", 1, 1'b1, 16'h0008, 4'hF, 32'hB2B2B2B2, 1'b1, 32'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 1'b0, 16'h0004, 4'h0, 32'd0);
        drive(1, 1'b0, 16'h0008, 4'h0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_addr", 32'(mem_address), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check("rr_rsp_id", 32'(bus.rsp_id), 32'(i % 2));
            check("rr_rsp_data", bus.rsp_data, (i % 2 == 0) ? 32'hA1A1A1A1 : 32'hB2B2B2B2);
        end
        clear();

        // requester 1 held off by RMW_WR, granted in the following IDLE cycle
        drive(0, 1'b1, 16'h0008, 4'b0001, 32'h000000EE);
        #1;
        check("hold_acc_ready", 32'(bus.req_ready), 32'd1);
        tick();
        clear();
        drive(1, 1'b0, 16'h0008, 4'h0, 32'd0);
        #1;
        check("hold_ready_wr", 32'(bus.req_ready), 32'd0);
        check("hold_wdata", mem_write_data, 32'hB2B2B2EE);
        tick();
        check("hold_rmw_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("hold_rmw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        #1;
        check("hold_ready_idle", 32'(bus.req_ready), 32'd2);
        tick();
        clear();
        check("hold_ld_id", 32'(bus.rsp_id), 32'd1);
        check("hold_ld_data", bus.rsp_data, 32'hB2B2B2EE);

        // reset landing on the write cycle of a partial store
        drive(1, 1'b1, 16'h0004, 4'b1000, 32'hFF000000);
        #1;
        check("rstw_acc_ready", 32'(bus.req_ready), 32'd2);
        tick();
        clear();
        reset = 1'b1;
        #1;
        check("rstw_we", 32'(mem_write_enable), 32'd0);
        check("rstw_ready", 32'(bus.req_ready), 32'd0);
        tick();
        reset = 1'b0;
        check("rstw_no_rsp0", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("rstw_no_rsp1", 32'(bus.rsp_valid), 32'd0);
        xact("rstw_readback", 0, 1'b0, 16'h0004, 4'h0, 32'd0, 1'b0, 32'hA1A1A1A1, 1'b0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
